// File: rtl/upb_coeff_update.sv
// G.726 UPB sixth-order predictor coefficient update with a registered result.
// The result register doubles as five DFT scan chains under test_mode/scan_enable.
module upb_coeff_update (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rate,
    input  logic        u,
    input  logic [15:0] b,
    input  logic [15:0] dq,
    input  logic        scan_in0,
    input  logic        scan_in1,
    input  logic        scan_in2,
    input  logic        scan_in3,
    input  logic        scan_in4,
    input  logic        scan_enable,
    input  logic        test_mode,
    output logic [15:0] bp,
    output logic        scan_out0,
    output logic        scan_out1,
    output logic        scan_out2,
    output logic        scan_out3,
    output logic        scan_out4
);

    localparam int unsigned W = 16;
    localparam logic [1:0] RATE_40K = 2'd3;

    logic          dq_zero;
    logic          sh9;
    logic [W-1:0]  ugb;
    logic [W-1:0]  bsh;
    logic [W-1:0]  bsh_ext;
    logic [W-1:0]  ulb;
    logic [W-1:0]  ub;
    logic [W-1:0]  bp_next;
    logic [W-1:0]  bp_shift;
    logic          shift_en;

    // Gain and leakage terms; the sign bit of dq does not affect the gain.
    always_comb begin
        dq_zero = ((dq & 16'h7FFF) == 16'h0000);
        sh9     = (rate == RATE_40K);
        ugb     = W'(0);
        if (!dq_zero) begin
            ugb = u ? 16'hFF80 : 16'h0080;
        end
        bsh     = sh9 ? (b >> 9) : (b >> 8);
        bsh_ext = bsh;
        if (b[15]) begin
            bsh_ext = W'(bsh + (sh9 ? 16'hFF80 : 16'hFF00));
        end
        ulb     = W'(W'(0) - bsh_ext);
        ub      = W'(ugb + ulb);
        bp_next = W'(b + ub);
    end

    // Each chain shifts toward higher bit indices; scan_inN enters the lowest bit.
    always_comb begin
        bp_shift = {bp[14:12], scan_in4,
                    bp[10:9],  scan_in3,
                    bp[7:6],   scan_in2,
                    bp[4:3],   scan_in1,
                    bp[1:0],   scan_in0};
        shift_en = test_mode & scan_enable;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bp <= W'(0);
        end else if (shift_en) begin
            bp <= bp_shift;
        end else begin
            bp <= bp_next;
        end
    end

    assign scan_out0 = bp[2];
    assign scan_out1 = bp[5];
    assign scan_out2 = bp[8];
    assign scan_out3 = bp[11];
    assign scan_out4 = bp[15];

endmodule

// File: tb/tb_upb_coeff_update.sv
// Bench for upb_coeff_update: directed vector table, scan sequences and a
// randomized run against an arithmetic reference model.
module tb_upb_coeff_update;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rate;
    logic        u;
    logic [15:0] b;
    logic [15:0] dq;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_enable;
    logic        test_mode;
    logic [15:0] bp;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int pass_cnt = 0;
    int total    = 0;

    upb_coeff_update dut (
        .clk(clk), .reset(reset), .rate(rate), .u(u), .b(b), .dq(dq),
        .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
        .scan_in3(scan_in3), .scan_in4(scan_in4),
        .scan_enable(scan_enable), .test_mode(test_mode), .bp(bp),
        .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
        .scan_out3(scan_out3), .scan_out4(scan_out4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rate;
        logic        u;
        logic [15:0] b;
        logic [15:0] dq;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[11];

    // Reference: bp = b + gain - (b arithmetically shifted right by 8 or 9), mod 2^16.
    function automatic logic [15:0] ref_next(input logic [1:0] r, input logic uu,
                                             input logic [15:0] bb, input logic [15:0] d);
        int bsv, gain, leak, sh;
        bsv  = int'($signed(bb));
        sh   = (r == 2'd3) ? 9 : 8;
        leak = bsv >>> sh;
        if (d[14:0] == 15'd0) gain = 0;
        else gain = uu ? -128 : 128;
        return 16'((bsv + gain - leak) & 32'hFFFF);
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h want %h", name, act, expv);
    endtask

    task automatic check1(input string name, input logic act, input logic expv);
        total++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %b want %b", name, act, expv);
    endtask

    task automatic check_outs(input string name, input logic [15:0] expv);
        check16(name, bp, expv);
        check16({name, "_scan"}, {11'd0, scan_out4, scan_out3, scan_out2, scan_out1, scan_out0},
                {11'd0, expv[15], expv[11], expv[8], expv[5], expv[2]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_scan_in(input logic [4:0] v);
        {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0} = v;
    endtask

    logic [15:0] m;
    int          starts[5] = '{0, 3, 6, 9, 12};
    int          lens[5]   = '{3, 3, 3, 3, 4};

    initial begin
        vecs[0]  = '{2'd2, 1'b0, 16'h0000, 16'h0001, 16'h0080};
        vecs[1]  = '{2'd2, 1'b1, 16'h0000, 16'h0001, 16'hFF80};
        vecs[2]  = '{2'd2, 1'b0, 16'h0000, 16'h8000, 16'h0000};
        vecs[3]  = '{2'd2, 1'b1, 16'h0000, 16'h8000, 16'h0000};
        vecs[4]  = '{2'd2, 1'b0, 16'h4000, 16'h0000, 16'h3FC0};
        vecs[5]  = '{2'd3, 1'b0, 16'h4000, 16'h0000, 16'h3FE0};
        vecs[6]  = '{2'd2, 1'b0, 16'hC000, 16'h0000, 16'hC040};
        vecs[7]  = '{2'd0, 1'b0, 16'hC000, 16'h0000, 16'hC040};
        vecs[8]  = '{2'd3, 1'b1, 16'hC000, 16'h0000, 16'hC020};
        vecs[9]  = '{2'd1, 1'b1, 16'h7FFF, 16'h1234, 16'h7F00};
        vecs[10] = '{2'd2, 1'b0, 16'hFFFF, 16'h0000, 16'h0000};

        // Reset with arbitrary inputs, scan shift requested too
        reset = 1'b1; rate = 2'd1; u = 1'b1; b = 16'h7ABC; dq = 16'h0F0F;
        test_mode = 1'b1; scan_enable = 1'b1; set_scan_in(5'b11111);
        step();
        check_outs("reset", 16'h0000);

        reset = 1'b0; test_mode = 1'b0; scan_enable = 1'b0; set_scan_in(5'b0);
        foreach (vecs[i]) begin
            rate = vecs[i].rate; u = vecs[i].u; b = vecs[i].b; dq = vecs[i].dq;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].expv);
        end

        // Scan shift from reset: chain0 depth 3, chain4 depth 4
        reset = 1'b1; step(); reset = 1'b0;
        b = 16'h1234; dq = 16'h0001; rate = 2'd2;
        test_mode = 1'b1; scan_enable = 1'b1; set_scan_in(5'b10001);
        for (int e = 1; e <= 4; e++) begin
            step();
            check1($sformatf("shift_out0_e%0d", e), scan_out0, e >= 3);
            check1($sformatf("shift_out4_e%0d", e), scan_out4, e >= 4);
            check1($sformatf("shift_out1_e%0d", e), scan_out1, 1'b0);
        end
        check16("shift_bp", bp, 16'hF007);

        // Reset mid-scan clears chain contents
        reset = 1'b1; step(); reset = 1'b0;
        check_outs("reset_midscan", 16'h0000);

        // scan_enable has no effect outside test mode
        test_mode = 1'b0; scan_enable = 1'b1; set_scan_in(5'b11111);
        b = 16'h4000; dq = 16'h0000; rate = 2'd2; u = 1'b0;
        step();
        check_outs("se_no_tm", 16'h3FC0);

        // Capture in test mode, then unload chain4 MSB-first
        test_mode = 1'b1; scan_enable = 1'b0; set_scan_in(5'b0);
        b = 16'h4000; dq = 16'h0000; rate = 2'd2;
        step();
        check_outs("tm_capture", 16'h3FC0);
        scan_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] cap;
            cap = 16'h3FC0;
            check1($sformatf("unload_bit%0d", 15 - k), scan_out4, cap[15 - k]);
            step();
        end

        // Randomized run against the reference model
        reset = 1'b1; step(); reset = 1'b0;
        m = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] si;
            reset       = ($urandom_range(0, 24) == 0);
            test_mode   = ($urandom_range(0, 3) == 0);
            scan_enable = $urandom_range(0, 1) == 1;
            si          = 5'($urandom);
            set_scan_in(si);
            rate = 2'($urandom);
            u    = 1'($urandom);
            b    = 16'($urandom);
            case ($urandom_range(0, 5))
                0: dq = 16'h0000;
                1: dq = 16'h8000;
                default: dq = 16'($urandom);
            endcase
            if (reset) begin
                m = 16'h0000;
            end else if (test_mode && scan_enable) begin
                for (int c = 0; c < 5; c++) begin
                    for (int k = lens[c] - 1; k > 0; k--) m[starts[c] + k] = m[starts[c] + k - 1];
                    m[starts[c]] = si[c];
                end
            end else begin
                m = ref_next(rate, u, b, dq);
            end
            step();
            check_outs($sformatf("rand%0d", i), m);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/upb_coeff_update.md
# upb_coeff_update

Sixth-order pole/zero predictor coefficient update unit (G.726 "UPB") for the single-resource MCAC ADPCM datapath. Each cycle it computes the next coefficient BP from the current coefficient B, quantized difference DQ, sign-correlation bit U and coding rate, then registers it. The output register is organised into five scan chains for DFT access, controlled by test_mode/scan_enable.

## Interface
- No parameters.
- clk  input  1  single clock; all flops rising-edge.
- reset  input  1  synchronous, active-high; clears all state.
- rate  input  2  coding rate: 0=16k, 1=24k, 2=32k, 3=40k.
- u  input  1  sign-correlation bit (0 = signs agree, 1 = signs differ).
- b  input  16  current coefficient, two's complement.
- dq  input  16  quantized difference, sign-magnitude (bit15 sign, bits14:0 magnitude).
- bp  output  16  registered updated coefficient, two's complement.
- scan_in0..scan_in4  input  1 each  serial scan data into chains 0..4.
- scan_enable  input  1  scan shift enable (effective only with test_mode=1).
- test_mode  input  1  DFT mode select.
- scan_out0..scan_out4  output  1 each  serial scan data from chains 0..4.

## Operation
- All arithmetic modulo 2^16, unsigned 16-bit wrap.
- dqmag = dq[14:0]; ugb = 0 if dqmag==0 (includes dq=0x8000), else 0x0080 if u=0, else 0xFF80.
- bs = b[15]; sh = 9 when rate=3, else 8; bsh = b >> sh (logical).
- ulb = (0x10000 − bsh) if bs=0, else (0x10000 − (bsh + 0xFF00 if sh=8, else bsh + 0xFF80)); truncate to 16 bits.
- ub = ugb + ulb; bp_next = b + ub.
- Register mode priority: reset=1 → bp=0; else test_mode=1 and scan_enable=1 → shift; else → bp ≤ bp_next (capture; also when test_mode=1, scan_enable=0).
- Scan chains (bit nearest scan_in loads first, scan_out = last bit):
  - chain0: scan_in0→bp[0]→bp[1]→bp[2]→scan_out0
  - chain1: scan_in1→bp[3]→bp[4]→bp[5]→scan_out1
  - chain2: scan_in2→bp[6]→bp[7]→bp[8]→scan_out2
  - chain3: scan_in3→bp[9]→bp[10]→bp[11]→scan_out3
  - chain4: scan_in4→bp[12]→bp[13]→bp[14]→bp[15]→scan_out4
- scan_outN are direct wires from the chain's last flop in all modes.
- scan_enable ignored when test_mode=0.

## Timing
- Latency 1 cycle: inputs sampled at edge k, bp valid after edge k.
- New result each cycle; no handshake.
- Reset value: bp=0x0000, all scan_out=0; reset wins over scan shift and capture.
- Reset mid-scan: chain contents lost, all zero next cycle.
- Shift: one bit per edge per chain; chain0–3 depth 3, chain4 depth 4.
- No combinational path from any input to any output.

## Test plan
- Reset: reset=1 one edge with arbitrary inputs → bp=0x0000, scan_out0..4=0.
- Gain: b=0, rate=2, dq=0x0001, u=0 → bp=0x0080; u=1 → bp=0xFF80; dq=0x8000 → bp=0x0000.
- Leak positive: b=0x4000, dq=0, rate=2 → bp=0x3FC0; rate=3 → bp=0x3FE0.
- Leak negative: b=0xC000, dq=0, rate=2 → bp=0xC040; rate=0 → bp=0xC040.
- Scan shift: after reset, test_mode=1, scan_enable=1, scan_in0=1, scan_in4=1 → scan_out0 rises after 3rd edge, scan_out4 after 4th; test_mode=0 with scan_enable=1 → normal capture.
- Scan capture/unload: capture bp=0x3FC0 with test_mode=1, scan_enable=0, then shift 4 cycles → scan_out4 emits bp[15],bp[14],bp[13],bp[12] = 0,0,1,1.
